// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/func constants, ALU op codes, bundle layout and decode types
package ctrl_pkg;

    localparam int ALU_BASE_W = 4;
    localparam int EX_FLAGS_W = 7;
    localparam int MEM_W      = 3;
    localparam int WB_W       = 3;

    // Bit offsets inside ex_ctrl (alu_op occupies the bits from EX_ALU_OP_LSB upward)
    localparam int EX_BLEZ       = 0;
    localparam int EX_BNE        = 1;
    localparam int EX_BEQ        = 2;
    localparam int EX_SIGNED_EXT = 3;
    localparam int EX_REG_DST    = 4;
    localparam int EX_SHAMT_SEL  = 5;
    localparam int EX_ALU_SRC_B  = 6;
    localparam int EX_ALU_OP_LSB = 7;

    localparam int MEM_LBU    = 0;
    localparam int MEM_TO_REG = 1;
    localparam int MEM_WRITE  = 2;

    localparam int WB_SYSCALL   = 0;
    localparam int WB_JAL       = 1;
    localparam int WB_REG_WRITE = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // shamt_sel=1 takes the shift amount from rs instead of the shamt field
    typedef struct packed {
        logic [ALU_BASE_W-1:0] alu_op;
        logic alu_src_b;
        logic shamt_sel;
        logic reg_dst;
        logic signed_ext;
        logic beq;
        logic bne;
        logic blez;
        logic mem_write;
        logic mem_to_reg;
        logic lbu;
        logic reg_write;
        logic jal;
        logic syscall;
        logic jmp;
        logic jr;
        logic uses_rt;
        logic legal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// rtl/ctrl_pipe_unit_if.sv - ID-stage inputs and per-stage control outputs of ctrl_pipe_unit
interface ctrl_pipe_unit_if #(
    parameter int ALU_OP_W = 4
);
    logic [31:0]         instr;
    logic                instr_valid;
    logic                stall;
    logic                flush;
    logic [31:0]         v0_val;
    logic [ALU_OP_W+6:0] ex_ctrl;
    logic [2:0]          mem_ctrl;
    logic [2:0]          wb_ctrl;
    logic [4:0]          ex_dst;
    logic [4:0]          mem_dst;
    logic [4:0]          wb_dst;
    logic                id_jmp;
    logic                id_jr;
    logic                id_jal;
    logic                load_use_stall;
    logic                illegal_instr;
    logic                halted;

    modport master (
        output instr, instr_valid, stall, flush, v0_val,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst,
        input  id_jmp, id_jr, id_jal, load_use_stall, illegal_instr, halted
    );

    modport slave (
        input  instr, instr_valid, stall, flush, v0_val,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst,
        output id_jmp, id_jr, id_jal, load_use_stall, illegal_instr, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - pure opcode/func decode; SRLV, XOR, LBU, BLEZ only with CTRL_EXT_EN
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fn,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                dec.legal     = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.uses_rt   = 1'b1;
                case (fn)
                    FN_SLL:          dec.alu_op = ALU_SLL;
                    FN_SRL:          dec.alu_op = ALU_SRL;
                    FN_SRA:          dec.alu_op = ALU_SRA;
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    FN_SLTU:         dec.alu_op = ALU_SLTU;
                    FN_JR: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.uses_rt   = 1'b0;
                        dec.jr        = 1'b1;
                    end
                    FN_SYSCALL: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.uses_rt   = 1'b0;
                        dec.syscall   = 1'b1;
                    end
`ifdef CTRL_EXT_EN
                    FN_SRLV: begin
                        dec.alu_op    = ALU_SRL;
                        dec.shamt_sel = 1'b1;
                    end
                    FN_XOR:          dec.alu_op = ALU_XOR;
`endif
                    default:         dec = '0;
                endcase
            end
            OP_J: begin
                dec.legal = 1'b1;
                dec.jmp   = 1'b1;
            end
            OP_JAL: begin
                dec.legal     = 1'b1;
                dec.jmp       = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.legal   = 1'b1;
                dec.alu_op  = ALU_SUB;
                dec.uses_rt = 1'b1;
                dec.beq     = (op == OP_BEQ);
                dec.bne     = (op == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.legal      = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = (op == OP_SLTI)  ? ALU_SLT  :
                                 (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.legal     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = (op == OP_ANDI) ? ALU_AND :
                                (op == OP_ORI)  ? ALU_OR  :
                                (op == OP_XORI) ? ALU_XOR : ALU_LUI;
            end
            OP_LW: begin
                dec.legal      = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.legal      = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.mem_write  = 1'b1;
                dec.uses_rt    = 1'b1;
            end
`ifdef CTRL_EXT_EN
            OP_BLEZ: begin
                dec.legal  = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.blez   = 1'b1;
            end
            OP_LBU: begin
                dec.legal      = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.signed_ext = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.lbu        = 1'b1;
                dec.reg_write  = 1'b1;
            end
`endif
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - EX/MEM/WB control pipeline, load-use hazard and SYSCALL halt FSM
// Optional SRLV/XOR/LBU/BLEZ decode is enabled by defining CTRL_EXT_EN.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int          ALU_OP_W     = 4,
    parameter logic [31:0] HALT_CODE    = 32'd10,
    parameter int          DRAIN_CYCLES = 3
) (
    input logic             clk,
    input logic             rst_n,
    ctrl_pipe_unit_if.slave bus
);

    localparam int EX_W  = ALU_OP_W + EX_FLAGS_W;
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    dec_t dec;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EX_W-1:0]  ex_ctrl_q, ex_ctrl_d;
    logic [MEM_W-1:0] ex_mem_q, ex_mem_d, mem_ctrl_q, mem_ctrl_d;
    logic [WB_W-1:0]  ex_wb_q, ex_wb_d, mem_wb_q, mem_wb_d, wb_ctrl_q, wb_ctrl_d;
    logic [4:0]       ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic [4:0]       rs, rt, rd, id_dst;
    logic             id_live, in_run, load_use, issue;

    ctrl_decode u_decode (
        .op  (bus.instr[31:26]),
        .fn  (bus.instr[5:0]),
        .dec (dec)
    );

    always_comb begin
        rs      = bus.instr[25:21];
        rt      = bus.instr[20:16];
        rd      = bus.instr[15:11];
        id_live = bus.instr_valid & ~bus.flush;
        in_run  = (state_q == ST_RUN);
        // Only a load sitting in EX can still hurt: its data is not forwardable until WB.
        load_use = id_live && ex_mem_q[MEM_TO_REG] && (ex_dst_q != 5'd0) &&
                   ((ex_dst_q == rs) || (dec.uses_rt && (ex_dst_q == rt)));
        issue   = id_live & ~load_use & dec.legal & in_run;
        id_dst  = 5'd0;
        if (dec.reg_write) begin
            id_dst = dec.jal ? 5'd31 : (dec.reg_dst ? rd : rt);
        end
    end

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_mem_d   = ex_mem_q;
        ex_wb_d    = ex_wb_q;
        ex_dst_d   = ex_dst_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_wb_d   = mem_wb_q;
        mem_dst_d  = mem_dst_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_dst_d   = wb_dst_q;
        if (!bus.stall) begin
            ex_ctrl_d = '0;
            ex_mem_d  = '0;
            ex_wb_d   = '0;
            ex_dst_d  = '0;
            if (issue) begin
                ex_ctrl_d = {ALU_OP_W'(dec.alu_op), dec.alu_src_b, dec.shamt_sel, dec.reg_dst,
                             dec.signed_ext, dec.beq, dec.bne, dec.blez};
                ex_mem_d  = {dec.mem_write, dec.mem_to_reg, dec.lbu};
                ex_wb_d   = {dec.reg_write, dec.jal, dec.syscall};
                ex_dst_d  = id_dst;
            end
            mem_ctrl_d = ex_mem_q;
            mem_wb_d   = ex_wb_q;
            mem_dst_d  = ex_dst_q;
            wb_ctrl_d  = mem_wb_q;
            wb_dst_d   = mem_dst_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    if (issue && dec.syscall && (bus.v0_val == HALT_CODE)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_d = ST_HALT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ex_ctrl_q  <= '0;
            ex_mem_q   <= '0;
            ex_wb_q    <= '0;
            ex_dst_q   <= '0;
            mem_ctrl_q <= '0;
            mem_wb_q   <= '0;
            mem_dst_q  <= '0;
            wb_ctrl_q  <= '0;
            wb_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_mem_q   <= ex_mem_d;
            ex_wb_q    <= ex_wb_d;
            ex_dst_q   <= ex_dst_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_wb_q   <= mem_wb_d;
            mem_dst_q  <= mem_dst_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_dst_q   <= wb_dst_d;
        end
    end

    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.mem_ctrl       = mem_ctrl_q;
    assign bus.wb_ctrl        = wb_ctrl_q;
    assign bus.ex_dst         = ex_dst_q;
    assign bus.mem_dst        = mem_dst_q;
    assign bus.wb_dst         = wb_dst_q;
    assign bus.id_jmp         = issue & dec.jmp;
    assign bus.id_jr          = issue & dec.jr;
    assign bus.id_jal         = issue & dec.jal;
    assign bus.load_use_stall = load_use;
    assign bus.illegal_instr  = id_live & ~dec.legal;
    assign bus.halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - scoreboard bench for ctrl_pipe_unit (honours CTRL_EXT_EN)
module tb_ctrl_pipe_unit;

    typedef struct packed {
        logic [10:0] ex;
        logic [2:0]  mem;
        logic [2:0]  wb;
        logic [4:0]  dst;
    } exp_t;

    localparam exp_t E_BUB   = '{ex: 11'h000, mem: 3'b000, wb: 3'b000, dst: 5'd0};
    localparam exp_t E_LW8   = '{ex: 11'h048, mem: 3'b010, wb: 3'b100, dst: 5'd8};
    localparam exp_t E_LW0   = '{ex: 11'h048, mem: 3'b010, wb: 3'b100, dst: 5'd0};
    localparam exp_t E_ADD10 = '{ex: 11'h010, mem: 3'b000, wb: 3'b100, dst: 5'd10};
    localparam exp_t E_ORI8  = '{ex: 11'h1c0, mem: 3'b000, wb: 3'b100, dst: 5'd8};
    localparam exp_t E_SW    = '{ex: 11'h048, mem: 3'b100, wb: 3'b000, dst: 5'd0};
    localparam exp_t E_SYS   = '{ex: 11'h000, mem: 3'b000, wb: 3'b001, dst: 5'd0};
    localparam exp_t E_JAL   = '{ex: 11'h000, mem: 3'b000, wb: 3'b110, dst: 5'd31};
    localparam exp_t E_XOR1  = '{ex: 11'h210, mem: 3'b000, wb: 3'b100, dst: 5'd1};
    localparam exp_t E_SUB5  = '{ex: 11'h090, mem: 3'b000, wb: 3'b100, dst: 5'd5};

    localparam logic [31:0] I_LW8   = {6'h23, 5'd9, 5'd8, 16'd0};
    localparam logic [31:0] I_LW0   = {6'h23, 5'd9, 5'd0, 16'd0};
    localparam logic [31:0] I_ADD   = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] I_ADD0  = {6'h00, 5'd0, 5'd11, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] I_ORI8  = {6'h0d, 5'd5, 5'd8, 16'h1234};
    localparam logic [31:0] I_SW8   = {6'h2b, 5'd3, 5'd8, 16'd4};
    localparam logic [31:0] I_SYS   = 32'h0000_000c;
    localparam logic [31:0] I_JAL   = {6'h03, 26'h10};
    localparam logic [31:0] I_JR    = {6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};
    localparam logic [31:0] I_XOR   = {6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h26};
    localparam logic [31:0] I_SUB   = {6'h00, 5'd6, 5'd7, 5'd5, 5'd0, 6'h22};
    localparam logic [31:0] I_ILL   = 32'hfc00_0000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    exp_t m_ex, m_mem, m_wb;

    ctrl_pipe_unit_if #(.ALU_OP_W(4)) bus ();

    ctrl_pipe_unit #(
        .ALU_OP_W     (4),
        .HALT_CODE    (32'd10),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] i, input logic f, input exp_t e);
        bus.instr       = i;
        bus.instr_valid = 1'b1;
        bus.flush       = f;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle();
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        sb_q.push_back(E_BUB);
        #1;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (!bus.stall) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : E_BUB;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = e;
        end
        n_checks += 3;
        if ({bus.ex_ctrl, bus.ex_dst} !== {m_ex.ex, m_ex.dst}) begin
            n_errors++;
            $display("FAIL ex_stage(%s): got ctrl=%h dst=%0d want ctrl=%h dst=%0d",
                     tag, bus.ex_ctrl, bus.ex_dst, m_ex.ex, m_ex.dst);
        end
        if ({bus.mem_ctrl, bus.mem_dst} !== {m_mem.mem, m_mem.dst}) begin
            n_errors++;
            $display("FAIL mem_stage(%s): got ctrl=%b dst=%0d want ctrl=%b dst=%0d",
                     tag, bus.mem_ctrl, bus.mem_dst, m_mem.mem, m_mem.dst);
        end
        if ({bus.wb_ctrl, bus.wb_dst} !== {m_wb.wb, m_wb.dst}) begin
            n_errors++;
            $display("FAIL wb_stage(%s): got ctrl=%b dst=%0d want ctrl=%b dst=%0d",
                     tag, bus.wb_ctrl, bus.wb_dst, m_wb.wb, m_wb.dst);
        end
    endtask

    task automatic do_reset(input logic st);
        rst_n           = 1'b0;
        bus.stall       = st;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.flush       = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_ex  = E_BUB;
        m_mem = E_BUB;
        m_wb  = E_BUB;
        n_checks++;
        if ({bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.ex_dst, bus.mem_dst, bus.wb_dst,
             bus.id_jmp, bus.id_jr, bus.id_jal, bus.load_use_stall, bus.illegal_instr,
             bus.halted} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: ex=%h mem=%b wb=%b dst=%0d/%0d/%0d halted=%0b want all 0",
                     bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.ex_dst, bus.mem_dst,
                     bus.wb_dst, bus.halted);
        end
        rst_n     = 1'b1;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        drive(I_ADD, 1'b0, E_ADD10);
        tick("rst_fill");
        bus.v0_val = 32'd10;
        drive(I_SYS, 1'b0, E_SYS);
        tick("rst_drain_entry");
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            idle();
            tick("rst_after");
            n_checks++;
            if (bus.halted !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_no_halt[%0d]: halted=%0b want 0", k, bus.halted);
            end
        end
        drive(I_JAL, 1'b0, E_JAL);
        n_checks++;
        if ({bus.id_jmp, bus.id_jr, bus.id_jal} !== 3'b101) begin
            n_errors++;
            $display("FAIL rst_run_jal: flags=%b want 101", {bus.id_jmp, bus.id_jr, bus.id_jal});
        end
        tick("rst_jal");
    endtask

    task automatic test_load_use();
        do_reset(1'b0);
        drive(I_LW8, 1'b0, E_LW8);
        tick("lu_lw");
        drive(I_ADD, 1'b0, E_BUB);
        n_checks++;
        if (bus.load_use_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_stall_add: got %0b want 1", bus.load_use_stall);
        end
        tick("lu_bubble");
        drive(I_ADD, 1'b0, E_ADD10);
        n_checks++;
        if (bus.load_use_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_release: got %0b want 0", bus.load_use_stall);
        end
        tick("lu_add");
        drive(I_LW8, 1'b0, E_LW8);
        tick("lu_lw2");
        drive(I_ORI8, 1'b0, E_ORI8);
        n_checks++;
        if (bus.load_use_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_rt_dest_only: got %0b want 0", bus.load_use_stall);
        end
        tick("lu_ori");
        drive(I_LW8, 1'b0, E_LW8);
        tick("lu_lw3");
        drive(I_SW8, 1'b0, E_BUB);
        n_checks++;
        if (bus.load_use_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_rt_source: got %0b want 1", bus.load_use_stall);
        end
        tick("lu_sw_bubble");
        drive(I_SW8, 1'b0, E_SW);
        tick("lu_sw");
        for (int k = 0; k < 3; k++) begin
            idle();
            tick("lu_drain");
        end
    endtask

    task automatic test_zero_and_flush();
        drive(I_LW0, 1'b0, E_LW0);
        tick("z_lw0");
        drive(I_ADD0, 1'b0, E_ADD10);
        n_checks++;
        if (bus.load_use_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_reg_no_stall: got %0b want 0", bus.load_use_stall);
        end
        tick("z_add");
        drive(I_LW8, 1'b0, E_LW8);
        tick("f_lw");
        drive(I_ADD, 1'b1, E_BUB);
        n_checks++;
        if ({bus.load_use_stall, bus.illegal_instr} !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_over_hazard: lus/ill=%b want 00",
                     {bus.load_use_stall, bus.illegal_instr});
        end
        tick("f_bubble");
        for (int k = 0; k < 3; k++) begin
            idle();
            tick("f_drain");
        end
    endtask

    task automatic test_redirect();
        drive(I_JAL, 1'b0, E_JAL);
        n_checks++;
        if ({bus.id_jmp, bus.id_jr, bus.id_jal} !== 3'b101) begin
            n_errors++;
            $display("FAIL redir_jal: flags=%b want 101", {bus.id_jmp, bus.id_jr, bus.id_jal});
        end
        tick("r_jal");
        drive(I_JR, 1'b0, E_BUB);
        n_checks++;
        if ({bus.id_jmp, bus.id_jr, bus.id_jal} !== 3'b010) begin
            n_errors++;
            $display("FAIL redir_jr: flags=%b want 010", {bus.id_jmp, bus.id_jr, bus.id_jal});
        end
        tick("r_jr");
        drive(I_JAL, 1'b1, E_BUB);
        n_checks++;
        if ({bus.id_jmp, bus.id_jr, bus.id_jal} !== 3'b000) begin
            n_errors++;
            $display("FAIL redir_killed: flags=%b want 000", {bus.id_jmp, bus.id_jr, bus.id_jal});
        end
        tick("r_killed");
        for (int k = 0; k < 3; k++) begin
            idle();
            tick("r_drain");
        end
    endtask

    task automatic test_ext();
        logic exp_ill;
        exp_t exp_xor;
`ifdef CTRL_EXT_EN
        exp_ill = 1'b0;
        exp_xor = E_XOR1;
`else
        exp_ill = 1'b1;
        exp_xor = E_BUB;
`endif
        drive(I_XOR, 1'b0, exp_xor);
        n_checks++;
        if (bus.illegal_instr !== exp_ill) begin
            n_errors++;
            $display("FAIL ext_xor_illegal: got %0b want %0b", bus.illegal_instr, exp_ill);
        end
        tick("x_xor");
        drive(I_ILL, 1'b0, E_BUB);
        n_checks++;
        if (bus.illegal_instr !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_op: got %0b want 1", bus.illegal_instr);
        end
        tick("x_ill");
        drive(I_ILL, 1'b1, E_BUB);
        n_checks++;
        if (bus.illegal_instr !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_killed: got %0b want 0", bus.illegal_instr);
        end
        tick("x_ill_flush");
        drive(I_SUB, 1'b0, E_SUB5);
        tick("x_sub");
        for (int k = 0; k < 3; k++) begin
            idle();
            tick("x_drain");
        end
    endtask

    task automatic test_syscall();
        do_reset(1'b0);
        bus.v0_val = 32'd1;
        drive(I_SYS, 1'b0, E_SYS);
        tick("s_sys1");
        for (int k = 0; k < 4; k++) begin
            idle();
            tick("s_sys1_after");
            n_checks++;
            if (bus.halted !== 1'b0) begin
                n_errors++;
                $display("FAIL sys_other_v0[%0d]: halted=%0b want 0", k, bus.halted);
            end
        end
        bus.v0_val = 32'd10;
        drive(I_SYS, 1'b0, E_SYS);
        tick("s_e0");
        drive(I_JAL, 1'b0, E_BUB);
        n_checks++;
        if ({bus.id_jmp, bus.id_jal, bus.halted} !== 3'b000) begin
            n_errors++;
            $display("FAIL drain_jal_suppressed: jmp/jal/halted=%b want 000",
                     {bus.id_jmp, bus.id_jal, bus.halted});
        end
        tick("s_e1");
        idle();
        tick("s_e2");
        n_checks++;
        if (bus.halted !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_early: halted=%0b want 0 after 2 drain cycles", bus.halted);
        end
        idle();
        tick("s_e3");
        n_checks++;
        if (bus.halted !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_on_time: halted=%0b want 1 after 3 drain cycles", bus.halted);
        end
        drive(I_ADD, 1'b0, E_BUB);
        tick("s_halt_bubble");
        n_checks++;
        if (bus.halted !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_absorbing: halted=%0b want 1", bus.halted);
        end
    endtask

    task automatic test_drain_stall();
        do_reset(1'b0);
        bus.v0_val = 32'd10;
        drive(I_SYS, 1'b0, E_SYS);
        tick("ds_e0");
        idle();
        tick("ds_e1");
        bus.stall       = 1'b1;
        bus.instr       = I_ADD;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick("ds_stalled");
            n_checks++;
            if (bus.halted !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_stall_hold[%0d]: halted=%0b want 0", k, bus.halted);
            end
        end
        bus.stall = 1'b0;
        idle();
        tick("ds_e2");
        n_checks++;
        if (bus.halted !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_stall_e2: halted=%0b want 0", bus.halted);
        end
        idle();
        tick("ds_e3");
        n_checks++;
        if (bus.halted !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_stall_e3: halted=%0b want 1", bus.halted);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.v0_val      = '0;
        m_ex            = E_BUB;
        m_mem           = E_BUB;
        m_wb            = E_BUB;
        test_reset();
        test_load_use();
        test_zero_and_flush();
        test_redirect();
        test_ext();
        test_syscall();
        test_drain_stall();
        do_reset(1'b1);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
